popcount_accumulator: RTL

POPCOUNT_ACCUMULATOR -- requirements
Module: popcount_accumulator

---
 rtl/popcount_accumulator_if.sv | 34 +++
 rtl/popcount_accumulator.sv | 124 ++++++++++++
 2 files changed

// File: rtl/popcount_accumulator_if.sv
// ============================================================================
// popcount_accumulator_if : beat input / result output bundle for the
//                           popcount accumulator.  Rev 1.0
// ============================================================================
`default_nettype none

interface popcount_accumulator_if #(
  parameter int ACC_W  = 12,
  parameter int BEAT_W = 8
);
  logic              in_valid;
  logic [3:0]        in_count;
  logic              in_last;
  logic              in_ready;
  logic [ACC_W-1:0]  thresh;
  logic              out_valid;
  logic              out_ready;
  logic [ACC_W-1:0]  out_sum;
  logic              out_act;
  logic [BEAT_W-1:0] out_beats;
  logic              out_ovf;

  modport master (
    output in_valid, in_count, in_last, thresh, out_ready,
    input  in_ready, out_valid, out_sum, out_act, out_beats, out_ovf
  );

  modport slave (
    input  in_valid, in_count, in_last, thresh, out_ready,
    output in_ready, out_valid, out_sum, out_act, out_beats, out_ovf
  );
endinterface

`default_nettype wire

// File: rtl/popcount_accumulator.sv
// ============================================================================
// popcount_accumulator : saturating sum of 4-bit popcount beats per vector,
//                        with threshold activation and overflow flag.  Rev 1.0
// ============================================================================
`default_nettype none

module popcount_accumulator #(
  parameter int ACC_W  = 12,
  parameter int BEAT_W = 8
) (
  input  wire logic              clk,
  input  wire logic              rst,
  popcount_accumulator_if.slave  bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACC  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [BEAT_W-1:0] beats_q, beats_d;
  logic              ovf_q, ovf_d;
  logic [ACC_W-1:0]  sum_out_q, sum_out_d;
  logic [BEAT_W-1:0] beats_out_q, beats_out_d;
  logic              act_q, act_d;
  logic              ovf_out_q, ovf_out_d;

  logic [ACC_W-1:0]  base_acc;
  logic [BEAT_W-1:0] base_beats;
  logic              base_ovf;
  logic [ACC_W:0]    sum_wide;
  logic [BEAT_W:0]   beats_wide;
  logic [ACC_W-1:0]  sum_sat;
  logic [BEAT_W-1:0] beats_sat;
  logic              ovf_next;
  logic              xfer_in;

  // A vector starting from IDLE adds onto zero, so first and later beats share one adder.
  always_comb begin
    base_acc   = (state_q == ST_IDLE) ? '0   : acc_q;
    base_beats = (state_q == ST_IDLE) ? '0   : beats_q;
    base_ovf   = (state_q == ST_IDLE) ? 1'b0 : ovf_q;

    sum_wide   = {1'b0, base_acc} + {{(ACC_W-3){1'b0}}, bus.in_count};
    beats_wide = {1'b0, base_beats} + {{BEAT_W{1'b0}}, 1'b1};
    sum_sat    = sum_wide[ACC_W]    ? {ACC_W{1'b1}}  : sum_wide[ACC_W-1:0];
    beats_sat  = beats_wide[BEAT_W] ? {BEAT_W{1'b1}} : beats_wide[BEAT_W-1:0];
    ovf_next   = base_ovf | sum_wide[ACC_W] | beats_wide[BEAT_W];

    xfer_in    = bus.in_valid & (state_q != ST_HOLD);
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    beats_d     = beats_q;
    ovf_d       = ovf_q;
    sum_out_d   = sum_out_q;
    beats_out_d = beats_out_q;
    act_d       = act_q;
    ovf_out_d   = ovf_out_q;

    case (state_q)
      ST_IDLE, ST_ACC: begin
        if (xfer_in) begin
          if (bus.in_last) begin
            // thresh is only looked at here; the registered act keeps it frozen.
            sum_out_d   = sum_sat;
            beats_out_d = beats_sat;
            act_d       = (sum_sat >= bus.thresh);
            ovf_out_d   = ovf_next;
            state_d     = ST_HOLD;
          end else begin
            acc_d   = sum_sat;
            beats_d = beats_sat;
            ovf_d   = ovf_next;
            state_d = ST_ACC;
          end
        end
      end
      ST_HOLD: begin
        if (bus.out_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      beats_q     <= '0;
      ovf_q       <= 1'b0;
      sum_out_q   <= '0;
      beats_out_q <= '0;
      act_q       <= 1'b0;
      ovf_out_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      beats_q     <= beats_d;
      ovf_q       <= ovf_d;
      sum_out_q   <= sum_out_d;
      beats_out_q <= beats_out_d;
      act_q       <= act_d;
      ovf_out_q   <= ovf_out_d;
    end
  end

  assign bus.in_ready  = (state_q != ST_HOLD);
  assign bus.out_valid = (state_q == ST_HOLD);
  assign bus.out_sum   = sum_out_q;
  assign bus.out_beats = beats_out_q;
  assign bus.out_act   = act_q;
  assign bus.out_ovf   = ovf_out_q;

endmodule

`default_nettype wire
